// File: rtl/spi_master_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : spi_master_ctrl_if                                         |
// | Description : Bundle of the host byte stream, status and SPI pin signals |
// |               of spi_master_ctrl.                                        |
// |               master modport = controller view, slave modport = host /   |
// |               pin-side view.                                             |
// | Ports       : tx_valid_i/tx_ready_o/tx_data_i/tx_last_i  tx word stream  |
// |               rx_valid_o/rx_data_o                       rx word pulse   |
// |               busy_o                                     not-idle flag   |
// |               spi_clk_o/spi_mosi_o/spi_cs_o/spi_miso_i   SPI pins        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface spi_master_ctrl_if #(
   parameter int DATA_W = 8
) ();
   logic              tx_valid_i;
   logic              tx_ready_o;
   logic [DATA_W-1:0] tx_data_i;
   logic              tx_last_i;
   logic              rx_valid_o;
   logic [DATA_W-1:0] rx_data_o;
   logic              busy_o;
   logic              spi_clk_o;
   logic              spi_mosi_o;
   logic              spi_cs_o;
   logic              spi_miso_i;

   modport master (
      input  tx_valid_i, tx_data_i, tx_last_i, spi_miso_i,
      output tx_ready_o, rx_valid_o, rx_data_o, busy_o,
             spi_clk_o, spi_mosi_o, spi_cs_o
   );

   modport slave (
      output tx_valid_i, tx_data_i, tx_last_i, spi_miso_i,
      input  tx_ready_o, rx_valid_o, rx_data_o, busy_o,
             spi_clk_o, spi_mosi_o, spi_cs_o
   );
endinterface
`default_nettype wire

// File: rtl/spi_master_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : spi_master_ctrl                                            |
// | Description : SPI mode-0 (CPOL=0, CPHA=0) initiator. Accepts words over  |
// |               a valid/ready stream, frames them under an active-low chip |
// |               select (one transaction per tx_last_i word) and returns    |
// |               each received word as a one-cycle rx_valid_o pulse.        |
// | Ports       : clk_i    system clock (rising edge)                        |
// |               rst_n_i  asynchronous active-low reset                     |
// |               bus      spi_master_ctrl_if.master (stream, status, pins)  |
// | Parameters  : DATA_W   bits per SPI word (>= 2)                          |
// |               CLK_DIV  clk_i cycles per SCLK half-period (>= 1)          |
// | Config      : SPI_MASTER_LSB_FIRST_EN defined -> words shifted LSB first |
// |               (default MSB first)                                        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module spi_master_ctrl #(
   parameter int DATA_W  = 8,
   parameter int CLK_DIV = 4
) (
   input  wire logic          clk_i,
   input  wire logic          rst_n_i,
   spi_master_ctrl_if.master  bus
);

   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_SHIFT = 3'd2,
      S_WAIT  = 3'd3,
      S_HOLD  = 3'd4,
      S_GAP   = 3'd5
   } state_t;

   state_t            state,    state_nxt;
   logic [CNT_W-1:0]  div_cnt,  div_cnt_nxt;
   logic [BIT_W-1:0]  bit_cnt,  bit_cnt_nxt;
   logic [DATA_W-1:0] tx_shift, tx_shift_nxt;
   logic [DATA_W-1:0] rx_shift, rx_shift_nxt;
   logic [DATA_W-1:0] rx_data,  rx_data_nxt;
   logic              last,     last_nxt;
   logic              cs,       cs_nxt;
   logic              sclk,     sclk_nxt;
   logic              mosi,     mosi_nxt;
   logic              ready,    ready_nxt;
   logic              rx_valid, rx_valid_nxt;
   logic              busy,     busy_nxt;

   logic              tick;
   logic              accept;
   logic [DATA_W-1:0] tx_adv;     // tx shift register after one bit has gone out
   logic [DATA_W-1:0] rx_ins;     // rx shift register with spi_miso_i inserted
   logic              load_bit;   // first bit of the word on tx_data_i
   logic              adv_bit;    // bit presented after the next falling edge

   assign tick   = (div_cnt == CNT_LAST);
   assign accept = bus.tx_valid_i & ready;

`ifdef SPI_MASTER_LSB_FIRST_EN
   assign tx_adv   = {1'b0, tx_shift[DATA_W-1:1]};
   assign rx_ins   = {bus.spi_miso_i, rx_shift[DATA_W-1:1]};
   assign load_bit = bus.tx_data_i[0];
   assign adv_bit  = tx_shift[1];
`else
   assign tx_adv   = {tx_shift[DATA_W-2:0], 1'b0};
   assign rx_ins   = {rx_shift[DATA_W-2:0], bus.spi_miso_i};
   assign load_bit = bus.tx_data_i[DATA_W-1];
   assign adv_bit  = tx_shift[DATA_W-2];
`endif

   // State and all registered outputs.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state    <= S_IDLE;
         div_cnt  <= '0;
         bit_cnt  <= '0;
         tx_shift <= '0;
         rx_shift <= '0;
         rx_data  <= '0;
         last     <= 1'b0;
         cs       <= 1'b1;
         sclk     <= 1'b0;
         mosi     <= 1'b0;
         ready    <= 1'b0;
         rx_valid <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_nxt;
         div_cnt  <= div_cnt_nxt;
         bit_cnt  <= bit_cnt_nxt;
         tx_shift <= tx_shift_nxt;
         rx_shift <= rx_shift_nxt;
         rx_data  <= rx_data_nxt;
         last     <= last_nxt;
         cs       <= cs_nxt;
         sclk     <= sclk_nxt;
         mosi     <= mosi_nxt;
         ready    <= ready_nxt;
         rx_valid <= rx_valid_nxt;
         busy     <= busy_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      bit_cnt_nxt  = bit_cnt;
      tx_shift_nxt = tx_shift;
      rx_shift_nxt = rx_shift;
      rx_data_nxt  = rx_data;
      last_nxt     = last;
      cs_nxt       = cs;
      sclk_nxt     = sclk;
      mosi_nxt     = mosi;
      ready_nxt    = ready;
      rx_valid_nxt = 1'b0;
      // Every timed state is entered on a tick or from IDLE/WAIT, so the
      // divider always starts a new state from zero.
      div_cnt_nxt  = tick ? '0 : div_cnt + 1'b1;

      case (state)
         S_IDLE: begin
            div_cnt_nxt = '0;
            ready_nxt   = 1'b1;
            if (accept) begin
               tx_shift_nxt = bus.tx_data_i;
               last_nxt     = bus.tx_last_i;
               mosi_nxt     = load_bit;
               cs_nxt       = 1'b0;
               ready_nxt    = 1'b0;
               bit_cnt_nxt  = '0;
               state_nxt    = S_SETUP;
            end
         end
         S_SETUP: begin
            // First rising edge also samples the first miso bit.
            if (tick) begin
               sclk_nxt     = 1'b1;
               rx_shift_nxt = rx_ins;
               state_nxt    = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (tick) begin
               if (sclk) begin
                  sclk_nxt = 1'b0;
                  if (bit_cnt == BIT_LAST) begin
                     rx_valid_nxt = 1'b1;
                     rx_data_nxt  = rx_shift;
                     ready_nxt    = ~last;
                     state_nxt    = last ? S_HOLD : S_WAIT;
                  end else begin
                     bit_cnt_nxt  = bit_cnt + 1'b1;
                     tx_shift_nxt = tx_adv;
                     mosi_nxt     = adv_bit;
                  end
               end else begin
                  sclk_nxt     = 1'b1;
                  rx_shift_nxt = rx_ins;
               end
            end
         end
         S_WAIT: begin
            div_cnt_nxt = '0;
            ready_nxt   = 1'b1;
            if (accept) begin
               tx_shift_nxt = bus.tx_data_i;
               last_nxt     = bus.tx_last_i;
               mosi_nxt     = load_bit;
               ready_nxt    = 1'b0;
               bit_cnt_nxt  = '0;
               state_nxt    = S_SETUP;
            end
         end
         S_HOLD: begin
            if (tick) begin
               cs_nxt    = 1'b1;
               state_nxt = S_GAP;
            end
         end
         S_GAP: begin
            // Minimum CS-high time before a new transaction may start.
            if (tick) begin
               ready_nxt = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: begin
            cs_nxt    = 1'b1;
            sclk_nxt  = 1'b0;
            ready_nxt = 1'b0;
            state_nxt = S_IDLE;
         end
      endcase

      busy_nxt = (state_nxt != S_IDLE);
   end

   assign bus.tx_ready_o = ready;
   assign bus.rx_valid_o = rx_valid;
   assign bus.rx_data_o  = rx_data;
   assign bus.busy_o     = busy;
   assign bus.spi_clk_o  = sclk;
   assign bus.spi_mosi_o = mosi;
   assign bus.spi_cs_o   = cs;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_spi_master_ctrl                                         |
// | Description : Directed bench for spi_master_ctrl. dut runs CLK_DIV=4     |
// |               with miso looped back from mosi; dut1 runs CLK_DIV=1 with  |
// |               miso tied high. Honours SPI_MASTER_LSB_FIRST_EN.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_spi_master_ctrl;

`ifdef SPI_MASTER_LSB_FIRST_EN
   localparam bit LSB_FIRST = 1'b1;
`else
   localparam bit LSB_FIRST = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   spi_master_ctrl_if #(.DATA_W(8)) bus  ();
   spi_master_ctrl_if #(.DATA_W(8)) bus1 ();

   assign bus.spi_miso_i  = bus.spi_mosi_o;
   assign bus1.spi_miso_i = 1'b1;

   spi_master_ctrl #(.DATA_W(8), .CLK_DIV(4)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   spi_master_ctrl #(.DATA_W(8), .CLK_DIV(1)) dut1 (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus1)
   );

   // Received-word log and CS rising-edge counter for dut.
   int          rx_cnt  = 0;
   int          cs_rise = 0;
   logic [23:0] rx_hist = '0;
   logic        cs_prev = 1'b1;

   always @(posedge clk) begin
      cs_prev <= bus.spi_cs_o;
      if (bus.spi_cs_o === 1'b1 && cs_prev === 1'b0) cs_rise <= cs_rise + 1;
      if (bus.rx_valid_o === 1'b1) begin
         rx_cnt  <= rx_cnt + 1;
         rx_hist <= {rx_hist[15:0], bus.rx_data_o};
      end
   end

   function automatic logic exp_bit(input logic [7:0] d, input int k);
      return LSB_FIRST ? d[k] : d[7-k];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Present a word to dut and return one step after the accepting edge.
   task automatic send(input logic [7:0] d, input logic l);
      int n;
      n = 0;
      bus.tx_valid_i = 1'b1;
      bus.tx_data_i  = d;
      bus.tx_last_i  = l;
      while (bus.tx_ready_o !== 1'b1 && n < 300) begin
         cyc(1);
         n++;
      end
      chk("send_ready_bound", 32'(n < 300), 32'd1);
      cyc(1);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (bus.busy_o !== 1'b0 && n < 2000) begin
         cyc(1);
         n++;
      end
      chk("idle_bound", 32'(n < 2000), 32'd1);
   endtask

   int rx_before;
   int cs_before;

   initial begin
      bus.tx_valid_i  = 1'b0;
      bus.tx_data_i   = '0;
      bus.tx_last_i   = 1'b0;
      bus1.tx_valid_i = 1'b0;
      bus1.tx_data_i  = '0;
      bus1.tx_last_i  = 1'b0;

      // Reset state
      cyc(3);
      chk("rst_cs",      bus.spi_cs_o,   1);
      chk("rst_sclk",    bus.spi_clk_o,  0);
      chk("rst_mosi",    bus.spi_mosi_o, 0);
      chk("rst_ready",   bus.tx_ready_o, 0);
      chk("rst_rxvalid", bus.rx_valid_o, 0);
      chk("rst_rxdata",  bus.rx_data_o,  0);
      chk("rst_busy",    bus.busy_o,     0);
      rst_n = 1'b1;
      cyc(1);
      chk("ready_after_rst", bus.tx_ready_o, 1);

      // Single byte A5 with loopback, latency profile
      send(8'hA5, 1'b1);
      bus.tx_valid_i = 1'b0;
      chk("t1_cs_fall",  bus.spi_cs_o,   0);
      chk("t1_ready_lo", bus.tx_ready_o, 0);
      chk("t1_busy",     bus.busy_o,     1);
      chk("t1_mosi0",    bus.spi_mosi_o, exp_bit(8'hA5, 0));
      cyc(3);
      chk("t1_sclk_setup", bus.spi_clk_o, 0);
      cyc(1);
      chk("t1_sclk_rise0", bus.spi_clk_o, 1);
      for (int k = 1; k < 8; k++) begin
         cyc(8);
         chk("t1_sclk_rise", bus.spi_clk_o, 1);
         chk("t1_mosi_bit",  bus.spi_mosi_o, exp_bit(8'hA5, k));
      end
      cyc(4);
      chk("t1_rxvalid",  bus.rx_valid_o, 1);
      chk("t1_rxdata",   bus.rx_data_o,  8'hA5);
      chk("t1_sclk_end", bus.spi_clk_o,  0);
      cyc(1);
      chk("t1_rxpulse", bus.rx_valid_o, 0);
      cyc(2);
      chk("t1_cs_hold", bus.spi_cs_o, 0);
      cyc(1);
      chk("t1_cs_rise", bus.spi_cs_o,   1);
      chk("t1_gap_rdy", bus.tx_ready_o, 0);
      cyc(3);
      chk("t1_gap_end", bus.tx_ready_o, 0);
      cyc(1);
      chk("t1_ready_back", bus.tx_ready_o, 1);
      chk("t1_busy_off",   bus.busy_o,     0);

      // Three-word frame "Hi\n" with valid held
      rx_before = rx_cnt;
      cs_before = cs_rise;
      send(8'h48, 1'b0);
      send(8'h69, 1'b0);
      send(8'h0A, 1'b1);
      bus.tx_valid_i = 1'b0;
      wait_idle();
      chk("t2_rx_count", rx_cnt - rx_before, 3);
      chk("t2_rx_words", rx_hist, 24'h48690A);
      chk("t2_cs_rises", cs_rise - cs_before, 1);

      // Word without last, long stall in WAIT, then closing word
      cs_before = cs_rise;
      send(8'h3C, 1'b0);
      bus.tx_valid_i = 1'b0;
      cyc(200);
      chk("t3_wait_cs",    bus.spi_cs_o,   0);
      chk("t3_wait_sclk",  bus.spi_clk_o,  0);
      chk("t3_wait_ready", bus.tx_ready_o, 1);
      chk("t3_wait_busy",  bus.busy_o,     1);
      chk("t3_rx_hold",    bus.rx_data_o,  8'h3C);
      send(8'hC3, 1'b1);
      bus.tx_valid_i = 1'b0;
      wait_idle();
      chk("t3_rx_second", rx_hist[7:0], 8'hC3);
      chk("t3_cs_high",   bus.spi_cs_o,  1);
      chk("t3_cs_rises",  cs_rise - cs_before, 1);

      // Asynchronous reset at the fourth SCLK rising edge
      rx_before = rx_cnt;
      send(8'h5A, 1'b1);
      bus.tx_valid_i = 1'b0;
      cyc(28);
      chk("t4_rise4",      bus.spi_clk_o,  1);
      chk("t4_mosi_bit3",  bus.spi_mosi_o, exp_bit(8'h5A, 3));
      rst_n = 1'b0;
      #1;
      chk("t4_async_cs",   bus.spi_cs_o,   1);
      chk("t4_async_sclk", bus.spi_clk_o,  0);
      chk("t4_async_mosi", bus.spi_mosi_o, 0);
      chk("t4_async_busy", bus.busy_o,     0);
      cyc(2);
      rst_n = 1'b1;
      chk("t4_no_rx", rx_cnt - rx_before, 0);
      cyc(1);
      chk("t4_ready", bus.tx_ready_o, 1);
      send(8'hFF, 1'b1);
      bus.tx_valid_i = 1'b0;
      wait_idle();
      chk("t4_rx_count", rx_cnt - rx_before, 1);
      chk("t4_rx_ff",    bus.rx_data_o, 8'hFF);

      // CLK_DIV=1 instance, miso tied high
      chk("t5_ready", bus1.tx_ready_o, 1);
      bus1.tx_valid_i = 1'b1;
      bus1.tx_data_i  = 8'h00;
      bus1.tx_last_i  = 1'b1;
      cyc(1);
      bus1.tx_valid_i = 1'b0;
      chk("t5_cs_fall", bus1.spi_cs_o, 0);
      cyc(1);
      chk("t5_sclk_hi", bus1.spi_clk_o, 1);
      cyc(1);
      chk("t5_sclk_lo", bus1.spi_clk_o, 0);
      cyc(13);
      chk("t5_rx_early", bus1.rx_valid_o, 0);
      cyc(1);
      chk("t5_rxvalid", bus1.rx_valid_o, 1);
      chk("t5_rxdata",  bus1.rx_data_o,  8'hFF);

      // Word 01 with loopback: first bit depends on configured order
      send(8'h01, 1'b1);
      bus.tx_valid_i = 1'b0;
      cyc(4);
      chk("t6_first_edge", bus.spi_mosi_o, exp_bit(8'h01, 0));
      cyc(8);
      chk("t6_second_edge", bus.spi_mosi_o, exp_bit(8'h01, 1));
      wait_idle();
      chk("t6_rxdata", bus.rx_data_o, 8'h01);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
